// File: rtl/div_iter_pkg.sv
// Shared types for the iterative restoring divider: FSM state encoding.
package div_iter_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_iter_step.sv
// Generic N-bit adder and the divider's combinational trial-subtract step built on it.
module div_iter_add #(
    parameter int N = 33
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         cin_i,
    output logic [N-1:0] sum_o
);
    assign sum_o = a_i + b_i + {{(N-1){1'b0}}, cin_i};
endmodule

module div_iter_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] rem_i,
    input  logic         quo_msb_i,
    input  logic [W-1:0] div_i,
    output logic [W-1:0] rem_o,
    output logic         qbit_o
);
    logic [W:0] shifted;
    logic [W:0] trial;

    assign shifted = {rem_i, quo_msb_i};

    // Subtract as shifted + ~{0,D} + 1; bit W of the result is the borrow.
    div_iter_add #(.N(W + 1)) u_add (
        .a_i   (shifted),
        .b_i   (~{1'b0, div_i}),
        .cin_i (1'b1),
        .sum_o (trial)
    );

    // The partial remainder always stays below D, so only its low W bits are kept.
    assign qbit_o = ~trial[W];
    assign rem_o  = trial[W] ? shifted[W-1:0] : trial[W-1:0];
endmodule

// File: rtl/div_iter.sv
// Multi-cycle restoring divider, one quotient bit per clock, start/done handshake.
// Define DIV_SIGNED_EN for two's-complement operands (magnitudes divided, signs restored on DONE).
module div_iter
    import div_iter_pkg::*;
#(
    parameter int W     = 32,
    parameter int CNT_W = 6
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         start,
    input  logic [W-1:0] in0,
    input  logic [W-1:0] in1,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] out0,
    output logic [W-1:0] out1,
    output logic         dz
);
    div_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [W-1:0]     rem_q;
    logic [W-1:0]     quo_q;
    logic [W-1:0]     div_q;
    logic [W-1:0]     rem_nxt;
    logic             qbit;
    logic [W-1:0]     quo_fin;
    logic [W-1:0]     rem_fin;
    logic [W-1:0]     dvd_cap;
    logic [W-1:0]     dvs_cap;

    div_iter_step #(.W(W)) u_step (
        .rem_i     (rem_q),
        .quo_msb_i (quo_q[W-1]),
        .div_i     (div_q),
        .rem_o     (rem_nxt),
        .qbit_o    (qbit)
    );

    assign quo_fin = {quo_q[W-2:0], qbit};
    assign rem_fin = rem_nxt;

`ifdef DIV_SIGNED_EN
    logic neg_quo_q;
    logic neg_rem_q;

    function automatic logic [W-1:0] mag(input logic [W-1:0] v);
        return v[W-1] ? -v : v;
    endfunction

    assign dvd_cap = mag(in0);
    assign dvs_cap = mag(in1);
`else
    assign dvd_cap = in0;
    assign dvs_cap = in1;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= DIV_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            div_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            out0    <= '0;
            out1    <= '0;
            dz      <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state_q)
                DIV_IDLE, DIV_DONE: begin
                    if (!start) begin
                        state_q <= DIV_IDLE;
                    end else if (in1 == '0) begin
                        // Divide by zero skips CALC entirely.
                        state_q <= DIV_DONE;
                        done    <= 1'b1;
                        out0    <= '1;
                        out1    <= in0;
                        dz      <= 1'b1;
                    end else begin
                        state_q <= DIV_CALC;
                        busy    <= 1'b1;
                        cnt_q   <= CNT_W'(W - 1);
                        rem_q   <= '0;
                        quo_q   <= dvd_cap;
                        div_q   <= dvs_cap;
`ifdef DIV_SIGNED_EN
                        neg_quo_q <= in0[W-1] ^ in1[W-1];
                        neg_rem_q <= in0[W-1];
`endif
                    end
                end
                DIV_CALC: begin
                    rem_q <= rem_nxt;
                    quo_q <= quo_fin;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == '0) begin
                        state_q <= DIV_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        dz      <= 1'b0;
`ifdef DIV_SIGNED_EN
                        out0 <= neg_quo_q ? -quo_fin : quo_fin;
                        out1 <= neg_rem_q ? -rem_fin : rem_fin;
`else
                        out0 <= quo_fin;
                        out1 <= rem_fin;
`endif
                    end
                end
                default: begin
                    state_q <= DIV_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end
endmodule
